// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: SHOW/BLANK slots per digit, frame tick on digit-0 wrap.
// Optional blink feature enabled by defining SEG_BLINK_EN (adds blink_mask port and frame counter).
module seg_scan_ctrl #(
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] digit_mask,
`ifdef SEG_BLINK_EN
   input  logic [7:0] blink_mask,
`endif
   output logic [2:0] sel,
   output logic [7:0] an_n,
   output logic       seg_blank,
   output logic       frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_sel;
   logic [7:0]    r_an_n;
   logic          r_blank;
   logic          r_tick;

   logic [1:0]    w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    w_sel_nxt;
   logic          w_tick_nxt;
   logic          w_blinked;
   logic          w_lit;
   logic [7:0]    w_an_nxt;
   logic          w_blank_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_tick_nxt  = 1'b0;
      if (!en) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_sel_nxt   = 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
               w_sel_nxt   = 3'd0;
            end
            ST_SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  w_state_nxt = ST_BLANK;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  // sel only moves here, so a lit digit never sees its select change
                  w_state_nxt = ST_SHOW;
                  w_cnt_nxt   = '0;
                  w_sel_nxt   = r_sel + 3'd1;
                  w_tick_nxt  = (r_sel == 3'd7);
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_sel_nxt   = 3'd0;
            end
         endcase
      end
   end

`ifdef SEG_BLINK_EN
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [FW-1:0] FDIV_LAST = FW'(BLINK_DIV - 1);

   logic [FW-1:0] r_fcnt;
   logic          r_phase;
   logic [FW-1:0] w_fcnt_nxt;
   logic          w_phase_nxt;

   always_comb begin
      w_fcnt_nxt  = r_fcnt;
      w_phase_nxt = r_phase;
      if (!en) begin
         w_fcnt_nxt  = '0;
         w_phase_nxt = 1'b0;
      end else if (w_tick_nxt) begin
         if (r_fcnt == FDIV_LAST) begin
            w_fcnt_nxt  = '0;
            w_phase_nxt = ~r_phase;
         end else begin
            w_fcnt_nxt = r_fcnt + FW'(1);
         end
      end
   end

   // Next-cycle phase so digit 0 obeys the new phase in the very first slot of the frame
   assign w_blinked = w_phase_nxt & blink_mask[w_sel_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt  <= '0;
         r_phase <= 1'b0;
      end else begin
         r_fcnt  <= w_fcnt_nxt;
         r_phase <= w_phase_nxt;
      end
   end
`else
   assign w_blinked = 1'b0;
`endif

   assign w_lit       = (w_state_nxt == ST_SHOW) && digit_mask[w_sel_nxt] && !w_blinked;
   assign w_an_nxt    = w_lit ? ~(8'b1 << w_sel_nxt) : 8'hFF;
   assign w_blank_nxt = (w_state_nxt != ST_SHOW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= 3'd0;
         r_an_n  <= 8'hFF;
         r_blank <= 1'b1;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
         r_an_n  <= w_an_nxt;
         r_blank <= w_blank_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   assign sel        = r_sel;
   assign an_n       = r_an_n;
   assign seg_blank  = r_blank;
   assign frame_tick = r_tick;

endmodule
